// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
// Busy mirrors ~Req_Ready for the hazard/stall logic.
interface data_mem_responder_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          Req_Valid;
    logic          Req_Ready;
    logic          Req_Wr;
    logic [AW-1:0] Req_Addr;
    logic [DW-1:0] Req_WData;
    logic          Rsp_Valid;
    logic          Rsp_Wr;
    logic [DW-1:0] Rsp_Data;
    logic          Rsp_Err;
    logic          Busy;

    modport master (
        output Req_Valid, Req_Wr, Req_Addr, Req_WData,
        input  Req_Ready, Rsp_Valid, Rsp_Wr, Rsp_Data, Rsp_Err, Busy
    );

    modport slave (
        input  Req_Valid, Req_Wr, Req_Addr, Req_WData,
        output Req_Ready, Rsp_Valid, Rsp_Wr, Rsp_Data, Rsp_Err, Busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering one load/store at a time after LATENCY cycles.
// Optional DMEM_RANGE_CHECK_EN: addresses >= DEPTH are flagged on Rsp_Err and have no effect.
module data_mem_responder #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                CLK,
    input  logic                RST,
    data_mem_responder_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ready, accept, req_err;
    logic          cap_wr, cap_err;
    logic [IW-1:0] cap_idx;
    logic [DW-1:0] cap_wdata;
    logic          do_access, acc_wr, acc_err;
    logic [IW-1:0] acc_idx;
    logic [DW-1:0] acc_wdata;
    logic [DW-1:0] rsp_data;
    logic [DW-1:0] mem [DEPTH];

`ifdef DMEM_RANGE_CHECK_EN
    if (IW < AW) begin : g_range
        assign req_err = |bus.Req_Addr[AW-1:IW];
    end else begin : g_full_range
        assign req_err = 1'b0;
    end
`else
    assign req_err = 1'b0;
`endif

    assign ready  = (state != WAIT);
    assign accept = bus.Req_Valid && ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (!accept) begin
                    state_nxt = IDLE;
                end else if (LATENCY == 1) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle latency performs the access on the live request; otherwise on the captured one.
    always_comb begin
        if (LATENCY == 1) begin
            do_access = accept;
            acc_wr    = bus.Req_Wr;
            acc_err   = req_err;
            acc_idx   = IW'(bus.Req_Addr);
            acc_wdata = bus.Req_WData;
        end else begin
            do_access = (state == WAIT) && (cnt == '0);
            acc_wr    = cap_wr;
            acc_err   = cap_err;
            acc_idx   = cap_idx;
            acc_wdata = cap_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_wr    <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            rsp_data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_wr    <= bus.Req_Wr;
                cap_err   <= req_err;
                cap_idx   <= IW'(bus.Req_Addr);
                cap_wdata <= bus.Req_WData;
            end
            if (do_access && !acc_wr) begin
                rsp_data <= acc_err ? '0 : mem[acc_idx];
            end
        end
    end

    // NOTE: the storage array is intentionally not reset so it can map onto a RAM macro.
    always_ff @(posedge CLK) begin
        if (do_access && acc_wr && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.Req_Ready = ready;
    assign bus.Busy      = ~ready;
    assign bus.Rsp_Valid = (state == RESP);
    assign bus.Rsp_Wr    = (state == RESP) && cap_wr;
    assign bus.Rsp_Err   = (state == RESP) && cap_err;
    assign bus.Rsp_Data  = rsp_data;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 1, 2, 3) checked every cycle against a
// cycle-counting transaction model, plus a vector table and hand-written corner sequences.
module tb_data_mem_responder;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int NDUT  = 3;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid [NDUT];
    logic          req_wr    [NDUT];
    logic [AW-1:0] req_addr  [NDUT];
    logic [DW-1:0] req_wdata [NDUT];
    wire  [NDUT-1:0] o_ready, o_valid, o_wr, o_err, o_busy;
    wire  [DW-1:0]   o_data [NDUT];

    // Instance g has LATENCY = g + 1.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_mem_responder_if #(.DW(DW), .AW(AW)) bus ();
        data_mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LATENCY(g + 1)) dut (
            .CLK(clk),
            .RST(rst),
            .bus(bus.slave)
        );
        assign bus.Req_Valid = req_valid[g];
        assign bus.Req_Wr    = req_wr[g];
        assign bus.Req_Addr  = req_addr[g];
        assign bus.Req_WData = req_wdata[g];
        assign o_ready[g]    = bus.Req_Ready;
        assign o_valid[g]    = bus.Rsp_Valid;
        assign o_wr[g]       = bus.Rsp_Wr;
        assign o_err[g]      = bus.Rsp_Err;
        assign o_busy[g]     = bus.Busy;
        assign o_data[g]     = bus.Rsp_Data;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference model: a request occupies the responder for LATENCY cycles
    // (none when LATENCY is 1), then answers for one cycle; memory effects apply at completion.
    int            busy_left  [NDUT];
    bit            resp_now   [NDUT];
    bit            cur_wr     [NDUT];
    bit            cur_err    [NDUT];
    logic [AW-1:0] cur_addr   [NDUT];
    logic [DW-1:0] cur_wdata  [NDUT];
    logic [DW-1:0] exp_data   [NDUT];
    bit            data_known [NDUT];
    logic [DW-1:0] mem_m      [NDUT][DEPTH];
    bit            mem_known  [NDUT][DEPTH];

    function automatic int lat_of(input int k);
        return k + 1;
    endfunction

    task automatic model_complete(input int k);
        int idx;
        idx = int'(cur_addr[k]) % DEPTH;
        if (cur_wr[k]) begin
            if (!cur_err[k]) begin
                mem_m[k][idx]     = cur_wdata[k];
                mem_known[k][idx] = 1'b1;
            end
        end else if (cur_err[k]) begin
            exp_data[k]   = '0;
            data_known[k] = 1'b1;
        end else begin
            exp_data[k]   = mem_m[k][idx];
            data_known[k] = mem_known[k][idx];
        end
    endtask

    task automatic model_edge(input int k, output bit acc);
        bit nxt;
        nxt = 1'b0;
        acc = 1'b0;
        if (busy_left[k] > 0) begin
            busy_left[k]--;
            nxt = (busy_left[k] == 0);
        end else if (req_valid[k]) begin
            acc          = 1'b1;
            cur_wr[k]    = req_wr[k];
            cur_addr[k]  = req_addr[k];
            cur_wdata[k] = req_wdata[k];
            cur_err[k]   = RC && (int'(req_addr[k]) >= DEPTH);
            if (lat_of(k) == 1) nxt = 1'b1;
            else busy_left[k] = lat_of(k);
        end
        if (nxt) model_complete(k);
        resp_now[k] = nxt;
    endtask

    task automatic check_outputs(input int k);
        string p;
        p = $sformatf("L%0d", lat_of(k));
        check({p, " req_ready"}, o_ready[k], busy_left[k] == 0);
        check({p, " busy"},      o_busy[k],  busy_left[k] != 0);
        check({p, " rsp_valid"}, o_valid[k], resp_now[k]);
        check({p, " rsp_wr"},    o_wr[k],    resp_now[k] && cur_wr[k]);
        check({p, " rsp_err"},   o_err[k],   resp_now[k] && cur_err[k]);
        if (data_known[k]) check({p, " rsp_data"}, o_data[k], exp_data[k]);
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, compare after.
    task automatic step(input int k, input bit v, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output bit acc, output bit gv,
                        output logic [DW-1:0] gd, output bit ge, output bit gw);
        req_valid[k] = v;
        req_wr[k]    = wr;
        req_addr[k]  = a;
        req_wdata[k] = d;
        @(posedge clk);
        model_edge(k, acc);
        @(negedge clk);
        check_outputs(k);
        gv = o_valid[k];
        gd = o_data[k];
        ge = o_err[k];
        gw = o_wr[k];
    endtask

    // lat = rising edges after the accepting edge before the response cycle.
    task automatic access(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [DW-1:0] gd, output bit ge, output bit gw);
        bit acc, gv;
        int n;
        acc = 1'b0;
        gv  = 1'b0;
        n   = 0;
        lat = 0;
        while (!acc && n < 20) begin
            step(k, 1'b1, wr, a, d, acc, gv, gd, ge, gw);
            n++;
        end
        if (!acc) begin
            check($sformatf("L%0d accept within 20 cycles", lat_of(k)), 32'(acc), 32'd1);
            return;
        end
        while (!gv && lat < 20) begin
            step(k, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom), acc, gv, gd, ge, gw);
            lat++;
        end
        if (!gv) check($sformatf("L%0d response within 20 cycles", lat_of(k)), 32'(gv), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            req_valid[k]  = 1'b0;
            busy_left[k]  = 0;
            resp_now[k]   = 1'b0;
            cur_wr[k]     = 1'b0;
            cur_err[k]    = 1'b0;
            exp_data[k]   = '0;
            data_known[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) check_outputs(k);
        rst = 1'b0;
    endtask

    task automatic run_random(input int k, input int n);
        bit acc, gv, ge, gw, v;
        logic [DW-1:0] gd;
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 4) == 0) a = {8'($urandom_range(1, 255)), 3'b000, 5'($urandom)};
            else a = 16'($urandom_range(0, 31));
            step(k, v, 1'($urandom), a, 16'($urandom), acc, gv, gd, ge, gw);
        end
        for (int i = 0; i < 6; i++) step(k, 1'b0, 1'b0, '0, '0, acc, gv, gd, ge, gw);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        bit            exp_err;
    } vec_t;
    localparam int NV = 10;
    vec_t tbl [NV];

    initial begin : main
        int lat, n_acc, n_rsp, n_low;
        logic [DW-1:0] gd;
        bit ge, gw, acc, gv;

        tbl[0] = '{1'b1, 16'h0003, 16'h1234, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b0};
        tbl[2] = '{1'b1, 16'h0005, 16'h5555, 16'h0000, 1'b0};
        tbl[3] = '{1'b1, 16'h0105, 16'hAAAA, 16'h0000, RC};
        tbl[4] = '{1'b0, 16'h0005, 16'h0000, RC ? 16'h5555 : 16'hAAAA, 1'b0};
        tbl[5] = '{1'b0, 16'h0105, 16'h0000, RC ? 16'h0000 : 16'hAAAA, RC};
        tbl[6] = '{1'b1, 16'h00FF, 16'h0F0F, 16'h0000, 1'b0};
        tbl[7] = '{1'b0, 16'h00FF, 16'h0000, 16'h0F0F, 1'b0};
        tbl[8] = '{1'b1, 16'hFFFF, 16'h7777, 16'h0000, RC};
        tbl[9] = '{1'b0, 16'h00FF, 16'h0000, RC ? 16'h0F0F : 16'h7777, 1'b0};

        for (int k = 0; k < NDUT; k++) begin
            req_valid[k] = 1'b0;
            req_wr[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
        end
        do_reset();

        // Vector table on the LATENCY=2 instance.
        for (int i = 0; i < NV; i++) begin
            access(1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, gd, ge, gw);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d rsp_wr", i), 32'(gw), 32'(tbl[i].wr));
            check($sformatf("vec%0d rsp_err", i), 32'(ge), 32'(tbl[i].exp_err));
            if (!tbl[i].wr) check($sformatf("vec%0d rsp_data", i), 32'(gd), 32'(tbl[i].exp_data));
        end

        // LATENCY=1: response in the cycle right after the accept edge, never busy.
        access(0, 1'b1, 16'h0000, 16'h00FF, lat, gd, ge, gw);
        check("L1 store latency", 32'(lat), 32'd0);
        access(0, 1'b0, 16'h0000, 16'h0000, lat, gd, ge, gw);
        check("L1 load latency", 32'(lat), 32'd0);
        check("L1 load data", 32'(gd), 32'h00FF);

        // LATENCY=3 with Req_Valid held high: one accept every 4 cycles, nothing lost.
        n_acc = 0;
        n_rsp = 0;
        n_low = 0;
        for (int i = 0; i < 16; i++) begin
            step(2, 1'b1, 1'((i >> 2) & 1), 16'(i), 16'hC000 + 16'(i), acc, gv, gd, ge, gw);
            n_acc += int'(acc);
            n_rsp += int'(gv);
            n_low += int'(!o_ready[2]);
        end
        for (int i = 0; i < 8; i++) begin
            step(2, 1'b0, 1'b0, '0, '0, acc, gv, gd, ge, gw);
            n_rsp += int'(gv);
        end
        check("L3 held-valid accepts", 32'(n_acc), 32'd4);
        check("L3 held-valid responses", 32'(n_rsp), 32'(n_acc));
        check("L3 ready-low cycles", 32'(n_low), 32'd12);

        // Reset in the middle of a store's wait: store dropped, no response.
        access(2, 1'b1, 16'h0005, 16'h1111, lat, gd, ge, gw);
        step(2, 1'b1, 1'b1, 16'h0005, 16'hBEEF, acc, gv, gd, ge, gw);
        check("L3 abort store accepted", 32'(acc), 32'd1);
        step(2, 1'b0, 1'b0, '0, '0, acc, gv, gd, ge, gw);
        #2 rst = 1'b1;
        #1;
        check("async reset req_ready", 32'(o_ready[2]), 32'd1);
        check("async reset busy", 32'(o_busy[2]), 32'd0);
        check("async reset rsp_valid", 32'(o_valid[2]), 32'd0);
        check("async reset rsp_data", 32'(o_data[2]), 32'd0);
        do_reset();
        n_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            step(2, 1'b0, 1'b0, '0, '0, acc, gv, gd, ge, gw);
            n_rsp += int'(gv);
        end
        check("no response for aborted store", 32'(n_rsp), 32'd0);
        access(2, 1'b0, 16'h0005, 16'h0000, lat, gd, ge, gw);
        check("load after aborted store", 32'(gd), 32'h1111);

        for (int k = 0; k < NDUT; k++) run_random(k, 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: run exceeded 30000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
